// File: rtl/ysyx_23060077_riscv_wbu.sv
// Write-back unit: retires ALU results directly and formats load data on the memory
// response, driving the register-file write port and a one-cycle commit pulse.
module ysyx_23060077_riscv_wbu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic                  in_rd_en,
  input  logic [REG_WIDTH-1:0]  in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_alu_data,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_op,
  input  logic [1:0]            in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rd_en,
  output logic [REG_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  commit_valid,
  output logic [31:0]           commit_pc,
  output logic                  busy
);

  localparam int unsigned PC_WIDTH = 32;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_e;

  state_e                state_q, state_d;

  logic [PC_WIDTH-1:0]   ld_pc_q, ld_pc_d;
  logic                  ld_rd_en_q, ld_rd_en_d;
  logic [REG_WIDTH-1:0]  ld_rd_addr_q, ld_rd_addr_d;
  logic [2:0]            ld_op_q, ld_op_d;
  logic [1:0]            ld_off_q, ld_off_d;

  logic                  rd_en_q, rd_en_d;
  logic [REG_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [PC_WIDTH-1:0]   commit_pc_q, commit_pc_d;

  logic [DATA_WIDTH-1:0] shifted_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_fmt_c;

  // Load alignment and extension from the latched funct3/offset
  always_comb begin
    shifted_c = mem_rdata >> {ld_off_q, 3'b000};
    byte_c    = shifted_c[7:0];
    half_c    = ld_off_q[1] ? mem_rdata[16 +: 16] : mem_rdata[0 +: 16];
    case (ld_op_q)
      3'b000:  load_fmt_c = {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
      3'b001:  load_fmt_c = {{(DATA_WIDTH-16){half_c[15]}}, half_c};
      3'b100:  load_fmt_c = DATA_WIDTH'(byte_c);
      3'b101:  load_fmt_c = DATA_WIDTH'(half_c);
      default: load_fmt_c = mem_rdata;
    endcase
  end

  // Next-state and registered outputs
  always_comb begin
    state_d        = state_q;
    ld_pc_d        = ld_pc_q;
    ld_rd_en_d     = ld_rd_en_q;
    ld_rd_addr_d   = ld_rd_addr_q;
    ld_op_d        = ld_op_q;
    ld_off_d       = ld_off_q;
    rd_en_d        = 1'b0;
    rd_addr_d      = rd_addr_q;
    rd_data_d      = rd_data_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            ld_pc_d      = in_pc;
            ld_rd_en_d   = in_rd_en && (in_rd_addr != '0);
            ld_rd_addr_d = in_rd_addr;
            ld_op_d      = in_load_op;
            ld_off_d     = in_addr_lo;
            state_d      = S_WAIT_MEM;
          end else begin
            rd_en_d        = in_rd_en && (in_rd_addr != '0);
            rd_addr_d      = in_rd_addr;
            rd_data_d      = in_alu_data;
            commit_valid_d = 1'b1;
            commit_pc_d    = in_pc;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          rd_en_d        = ld_rd_en_q;
          rd_addr_d      = ld_rd_addr_q;
          rd_data_d      = load_fmt_c;
          commit_valid_d = 1'b1;
          commit_pc_d    = ld_pc_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ld_pc_q        <= '0;
      ld_rd_en_q     <= 1'b0;
      ld_rd_addr_q   <= '0;
      ld_op_q        <= '0;
      ld_off_q       <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
    end else begin
      state_q        <= state_d;
      ld_pc_q        <= ld_pc_d;
      ld_rd_en_q     <= ld_rd_en_d;
      ld_rd_addr_q   <= ld_rd_addr_d;
      ld_op_q        <= ld_op_d;
      ld_off_q       <= ld_off_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q == S_WAIT_MEM);
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;

endmodule
